// File: rtl/hit_judge_if.sv
// hit_judge_if: game-state, button and zone inputs plus the judge's pulse and
// debug outputs, bundled so they can be passed around as one port.
//   state         game-state code from the top-level FSM
//   btn           raw asynchronous buttons, one per lane, active-high
//   arrow_in_zone per-lane level: the lane's arrow is inside the hit window
//   correctHit    one-cycle pulse per correct hit
//   incorrectHit  one-cycle pulse per miss or wrong press
//   lane_state    per-lane FSM state, {lane[LANES-1]..lane[0]}, 2 bits each
// master: drives the inputs (game top / testbench); slave: the judge itself.
interface hit_judge_if #(
  parameter int LANES      = 4,
  parameter int STATE_BITS = 1
);
  logic [STATE_BITS:0]  state;
  logic [LANES-1:0]     btn;
  logic [LANES-1:0]     arrow_in_zone;
  logic                 correctHit;
  logic                 incorrectHit;
  logic [2*LANES-1:0]   lane_state;

  modport master (
    output state, btn, arrow_in_zone,
    input  correctHit, incorrectHit, lane_state
  );

  modport slave (
    input  state, btn, arrow_in_zone,
    output correctHit, incorrectHit, lane_state
  );
endinterface

// File: rtl/hit_judge.sv
// hit_judge: judges button presses against arrows in the target zone, per
// lane, and feeds the scoring stage with single-cycle correctHit /
// incorrectHit pulses. Events from several lanes in one cycle are counted
// and replayed one pulse per cycle per kind.
//   clk  system clock
//   rst  asynchronous, active-high reset
//   bus  hit_judge_if.slave (state, btn, arrow_in_zone in;
//        correctHit, incorrectHit, lane_state out)
module hit_judge #(
  parameter int LANES       = 4,
  parameter int STATE_BITS  = 1,
  parameter int STATE_RESET = 0,
  parameter int STATE_GAME  = 1,
  parameter int STATE_PAUSE = 2,
  parameter int QDEPTH_W    = 3
) (
  input  logic        clk,
  input  logic        rst,
  hit_judge_if.slave  bus
);

  typedef enum logic [1:0] {
    L_IDLE  = 2'b00,
    L_ARMED = 2'b01,
    L_HIT   = 2'b10,
    L_BAD   = 2'b11
  } lane_st_e;

  localparam int ADDW = $clog2(LANES + 1);
  localparam int SUMW = QDEPTH_W + ADDW + 1;
  localparam logic [QDEPTH_W-1:0]  CNT_MAX  = '1;
  localparam logic [STATE_BITS:0]  ST_RESET = (STATE_BITS+1)'(STATE_RESET);
  localparam logic [STATE_BITS:0]  ST_GAME  = (STATE_BITS+1)'(STATE_GAME);
  localparam logic [STATE_BITS:0]  ST_PAUSE = (STATE_BITS+1)'(STATE_PAUSE);

  logic [LANES-1:0]    btn_s1_q, btn_s1_d;
  logic [LANES-1:0]    btn_s2_q, btn_s2_d;
  logic [LANES-1:0]    btn_s3_q, btn_s3_d;
  logic [LANES-1:0]    zone_q, zone_d;
  lane_st_e            lane_q [LANES];
  lane_st_e            lane_d [LANES];
  logic [QDEPTH_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [QDEPTH_W-1:0] inc_cnt_q, inc_cnt_d;
  logic                correct_hit_q, correct_hit_d;
  logic                incorrect_hit_q, incorrect_hit_d;

  logic                game, clr, paused;
  logic [LANES-1:0]    press, rise, fall;
  logic [ADDW-1:0]     corr_add, inc_add;

  // Add this cycle's events, remove the one being drained, clamp at the top.
  function automatic logic [QDEPTH_W-1:0] next_cnt(
    input logic [QDEPTH_W-1:0] cnt,
    input logic [ADDW-1:0]     add,
    input logic                drain
  );
    logic [SUMW-1:0] sum;
    sum = SUMW'(cnt) + SUMW'(add) - SUMW'(drain);
    if (sum > SUMW'(CNT_MAX)) return CNT_MAX;
    return sum[QDEPTH_W-1:0];
  endfunction

  // Unknown state codes behave exactly like pause.
  assign game   = (bus.state == ST_GAME);
  assign clr    = (bus.state == ST_RESET);
  assign paused = (bus.state == ST_PAUSE) || !(game || clr);

  // Button synchroniser keeps running in every state so a button held
  // through a pause produces no edge on resume; the zone history flop is
  // frozen during pause so an arrow entering then is still seen afterwards.
  always_comb begin
    btn_s1_d = bus.btn;
    btn_s2_d = btn_s1_q;
    btn_s3_d = btn_s2_q;
    zone_d   = paused ? zone_q : bus.arrow_in_zone;
    press    = btn_s2_q & ~btn_s3_q;
    rise     = bus.arrow_in_zone & ~zone_q;
    fall     = zone_q & ~bus.arrow_in_zone;
  end

  // Per-lane judging FSMs plus per-cycle event tallies.
  always_comb begin
    corr_add = '0;
    inc_add  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_d[i] = lane_q[i];
      if (clr) begin
        lane_d[i] = L_IDLE;
      end else if (game) begin
        case (lane_q[i])
          L_IDLE: begin
            if (press[i]) inc_add = inc_add + ADDW'(1);
            if (rise[i])  lane_d[i] = L_ARMED;
          end
          L_ARMED: begin
            if (press[i]) begin
              corr_add  = corr_add + ADDW'(1);
              lane_d[i] = fall[i] ? L_IDLE : L_HIT;
            end else if (fall[i]) begin
              inc_add   = inc_add + ADDW'(1);
              lane_d[i] = L_IDLE;
            end
          end
          L_HIT: begin
            if (press[i]) inc_add = inc_add + ADDW'(1);
            if (fall[i])  lane_d[i] = L_IDLE;
          end
          default: lane_d[i] = L_IDLE;
        endcase
      end
    end
  end

  // Event counters and pulse drain; both kinds drain independently.
  always_comb begin
    corr_cnt_d      = corr_cnt_q;
    inc_cnt_d       = inc_cnt_q;
    correct_hit_d   = 1'b0;
    incorrect_hit_d = 1'b0;
    if (clr) begin
      corr_cnt_d = '0;
      inc_cnt_d  = '0;
    end else if (game) begin
      correct_hit_d   = (corr_cnt_q != '0);
      incorrect_hit_d = (inc_cnt_q != '0);
      corr_cnt_d      = next_cnt(corr_cnt_q, corr_add, correct_hit_d);
      inc_cnt_d       = next_cnt(inc_cnt_q, inc_add, incorrect_hit_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1_q        <= '0;
      btn_s2_q        <= '0;
      btn_s3_q        <= '0;
      zone_q          <= '0;
      corr_cnt_q      <= '0;
      inc_cnt_q       <= '0;
      correct_hit_q   <= 1'b0;
      incorrect_hit_q <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) lane_q[i] <= L_IDLE;
    end else begin
      btn_s1_q        <= btn_s1_d;
      btn_s2_q        <= btn_s2_d;
      btn_s3_q        <= btn_s3_d;
      zone_q          <= zone_d;
      corr_cnt_q      <= corr_cnt_d;
      inc_cnt_q       <= inc_cnt_d;
      correct_hit_q   <= correct_hit_d;
      incorrect_hit_q <= incorrect_hit_d;
      for (int unsigned i = 0; i < LANES; i++) lane_q[i] <= lane_d[i];
    end
  end

  assign bus.correctHit   = correct_hit_q;
  assign bus.incorrectHit = incorrect_hit_q;

  always_comb begin
    bus.lane_state = '0;
    for (int unsigned i = 0; i < LANES; i++) bus.lane_state[2*i +: 2] = lane_q[i];
  end

endmodule

// File: tb/tb_hit_judge.sv
module tb_hit_judge;

  localparam logic [1:0] ST_R = 2'd0;
  localparam logic [1:0] ST_G = 2'd1;
  localparam logic [1:0] ST_P = 2'd2;
  localparam logic [1:0] ST_X = 2'd3;

  logic clk = 1'b0;
  logic rst;

  hit_judge_if #(.LANES(4), .STATE_BITS(1)) bus ();

  hit_judge #(
    .LANES(4), .STATE_BITS(1), .STATE_RESET(0),
    .STATE_GAME(1), .STATE_PAUSE(2), .QDEPTH_W(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] st;
    logic [3:0] btn;
    logic [3:0] zone;
    logic       corr;
    logic       inc;
    logic [7:0] lane;
  } vec_t;

  vec_t vq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add_vec(input logic [1:0] st, input logic [3:0] b, input logic [3:0] z,
                         input logic c, input logic i, input logic [7:0] l);
    vec_t v;
    v.st = st; v.btn = b; v.zone = z; v.corr = c; v.inc = i; v.lane = l;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arm the masked lanes, press them once; on return their events are counted.
  task automatic arm_and_press(input logic [3:0] mask);
    bus.arrow_in_zone = mask; tick();
    bus.btn = mask;           tick();
    tick();
    bus.btn = 4'b0000;        tick();
  endtask

  task automatic wait_corr(input string name);
    int cyc = 0;
    while (!bus.correctHit && cyc < 6) begin
      tick();
      cyc++;
    end
    check(name, cyc, 32'(bus.correctHit), 32'd1);
  endtask

  task automatic count_pulses(input int cycles, output int nc, output int ni);
    nc = 0; ni = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (bus.correctHit)   nc++;
      if (bus.incorrectHit) ni++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

  initial begin
    int nc, ni;

    // Lane 0: arm, hold button 3 cycles, one correct; then zone leaves.
    add_vec(ST_G, 4'h0, 4'h1, 0, 0, 8'h01);
    add_vec(ST_G, 4'h1, 4'h1, 0, 0, 8'h01);
    add_vec(ST_G, 4'h1, 4'h1, 0, 0, 8'h01);
    add_vec(ST_G, 4'h1, 4'h1, 0, 0, 8'h02);
    add_vec(ST_G, 4'h0, 4'h1, 1, 0, 8'h02);
    add_vec(ST_G, 4'h0, 4'h1, 0, 0, 8'h02);
    add_vec(ST_G, 4'h0, 4'h0, 0, 0, 8'h00);
    // Lane 2: armed, zone falls without a press -> miss.
    add_vec(ST_G, 4'h0, 4'h4, 0, 0, 8'h10);
    add_vec(ST_G, 4'h0, 4'h4, 0, 0, 8'h10);
    add_vec(ST_G, 4'h0, 4'h0, 0, 0, 8'h00);
    add_vec(ST_G, 4'h0, 4'h0, 0, 1, 8'h00);
    add_vec(ST_G, 4'h0, 4'h0, 0, 0, 8'h00);
    // All lanes armed and pressed together -> 4 consecutive corrects.
    add_vec(ST_G, 4'h0, 4'hF, 0, 0, 8'h55);
    add_vec(ST_G, 4'hF, 4'hF, 0, 0, 8'h55);
    add_vec(ST_G, 4'hF, 4'hF, 0, 0, 8'h55);
    add_vec(ST_G, 4'h0, 4'hF, 0, 0, 8'hAA);
    add_vec(ST_G, 4'h0, 4'hF, 1, 0, 8'hAA);
    add_vec(ST_G, 4'h0, 4'hF, 1, 0, 8'hAA);
    add_vec(ST_G, 4'h0, 4'hF, 1, 0, 8'hAA);
    add_vec(ST_G, 4'h0, 4'hF, 1, 0, 8'hAA);
    add_vec(ST_G, 4'h0, 4'hF, 0, 0, 8'hAA);
    add_vec(ST_G, 4'h0, 4'h0, 0, 0, 8'h00);
    // Lane 1 idle press + lane 3 armed press -> both pulses same cycle.
    add_vec(ST_G, 4'h0, 4'h8, 0, 0, 8'h40);
    add_vec(ST_G, 4'hA, 4'h8, 0, 0, 8'h40);
    add_vec(ST_G, 4'hA, 4'h8, 0, 0, 8'h40);
    add_vec(ST_G, 4'h0, 4'h8, 0, 0, 8'h80);
    add_vec(ST_G, 4'h0, 4'h8, 1, 1, 8'h80);
    add_vec(ST_G, 4'h0, 4'h8, 0, 0, 8'h80);
    add_vec(ST_G, 4'h0, 4'h0, 0, 0, 8'h00);
    // Lane 0 double-tap while in HIT -> correct then incorrect.
    add_vec(ST_G, 4'h0, 4'h1, 0, 0, 8'h01);
    add_vec(ST_G, 4'h1, 4'h1, 0, 0, 8'h01);
    add_vec(ST_G, 4'h1, 4'h1, 0, 0, 8'h01);
    add_vec(ST_G, 4'h0, 4'h1, 0, 0, 8'h02);
    add_vec(ST_G, 4'h1, 4'h1, 1, 0, 8'h02);
    add_vec(ST_G, 4'h1, 4'h1, 0, 0, 8'h02);
    add_vec(ST_G, 4'h0, 4'h1, 0, 0, 8'h02);
    add_vec(ST_G, 4'h0, 4'h1, 0, 1, 8'h02);
    add_vec(ST_G, 4'h0, 4'h0, 0, 0, 8'h00);
    // Lane 0: press and zone fall in the same cycle -> correct, straight to IDLE.
    add_vec(ST_G, 4'h0, 4'h1, 0, 0, 8'h01);
    add_vec(ST_G, 4'h1, 4'h1, 0, 0, 8'h01);
    add_vec(ST_G, 4'h1, 4'h1, 0, 0, 8'h01);
    add_vec(ST_G, 4'h0, 4'h0, 0, 0, 8'h00);
    add_vec(ST_G, 4'h0, 4'h0, 1, 0, 8'h00);
    add_vec(ST_G, 4'h0, 4'h0, 0, 0, 8'h00);

    rst = 1'b1;
    bus.state = ST_R;
    bus.btn = 4'b0000;
    bus.arrow_in_zone = 4'b0000;
    tick(); tick();
    check("rst_corr", 0, 32'(bus.correctHit), 32'd0);
    check("rst_inc",  0, 32'(bus.incorrectHit), 32'd0);
    check("rst_lane", 0, 32'(bus.lane_state), 32'd0);
    rst = 1'b0;
    bus.state = ST_G;
    tick();
    check("post_rst_lane", 0, 32'(bus.lane_state), 32'd0);

    foreach (vq[k]) begin
      bus.state         = vq[k].st;
      bus.btn           = vq[k].btn;
      bus.arrow_in_zone = vq[k].zone;
      tick();
      check("vec_corr", k, 32'(bus.correctHit), 32'(vq[k].corr));
      check("vec_inc",  k, 32'(bus.incorrectHit), 32'(vq[k].inc));
      check("vec_lane", k, 32'(bus.lane_state), 32'(vq[k].lane));
    end

    // Three corrects queued, pause (and an unknown code) after the first.
    arm_and_press(4'b0111);
    wait_corr("pause_first");
    bus.state = ST_P;
    count_pulses(3, nc, ni);
    bus.state = ST_X;
    count_pulses(3, nc, ni);
    check("pause_pulses", 0, 32'(nc + ni), 32'd0);
    check("pause_lane", 0, 32'(bus.lane_state), 32'h2A);
    bus.state = ST_G;
    count_pulses(6, nc, ni);
    check("resume_corr", 0, 32'(nc), 32'd2);
    check("resume_inc",  0, 32'(ni), 32'd0);
    bus.arrow_in_zone = 4'b0000;
    tick();
    check("resume_lane", 0, 32'(bus.lane_state), 32'd0);

    // Same, but the game-reset state clears the queue.
    arm_and_press(4'b0111);
    wait_corr("sreset_first");
    bus.state = ST_R;
    count_pulses(3, nc, ni);
    check("sreset_pulses", 0, 32'(nc + ni), 32'd0);
    check("sreset_lane", 0, 32'(bus.lane_state), 32'd0);
    bus.state = ST_G;
    count_pulses(6, nc, ni);
    check("sreset_after", 0, 32'(nc + ni), 32'd0);
    bus.arrow_in_zone = 4'b0000;
    tick();

    // Asynchronous reset in the middle of a drain.
    arm_and_press(4'b1111);
    wait_corr("arst_first");
    #2 rst = 1'b1;
    #1;
    check("arst_corr", 0, 32'(bus.correctHit), 32'd0);
    check("arst_lane", 0, 32'(bus.lane_state), 32'd0);
    bus.arrow_in_zone = 4'b0000;
    tick();
    rst = 1'b0;
    count_pulses(8, nc, ni);
    check("arst_after", 0, 32'(nc + ni), 32'd0);

    // Saturation: 12 idle-lane presses at 4 per 2 cycles; the counter
    // reaches 8 on the third burst and clamps to 7, so 11 pulses emerge.
    nc = 0; ni = 0;
    for (int k = 0; k < 6; k++) begin
      bus.btn = (k % 2 == 0) ? 4'b1111 : 4'b0000;
      tick();
      if (bus.correctHit)   nc++;
      if (bus.incorrectHit) ni++;
    end
    begin
      int nc2, ni2;
      count_pulses(20, nc2, ni2);
      nc += nc2;
      ni += ni2;
    end
    check("sat_inc",  0, 32'(ni), 32'd11);
    check("sat_corr", 0, 32'(nc), 32'd0);
    check("sat_lane", 0, 32'(bus.lane_state), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
